// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encoding, the frame length and an index-width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    // start bit + 8 data bits + stop bit
    localparam int FRAME_BITS = 10;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner selection: the search starts at the
// requester after i_last and wraps; o_valid is low when nothing requests.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    localparam logic [IDX_W:0] NREQ_W = (IDX_W + 1)'(NREQ);

    logic [IDX_W:0] w_sum;

    // Walk candidates from farthest to nearest so the nearest requester
    // after i_last is the one left standing.
    always_comb begin
        w_sum   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            w_sum = {1'b0, i_last} + (IDX_W + 1)'(k);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            if (i_req[w_sum[IDX_W-1:0]]) begin
                o_idx   = w_sum[IDX_W-1:0];
                o_valid = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign o_gnt[gi] = o_valid && (o_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ requesters: IDLE -> LOAD -> SEND -> GAP.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 9600,
    parameter int NREQ     = 4,
    parameter int GAP_CYC  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] din,
    output logic [NREQ-1:0]   gnt,
    output logic              uart_en,
    output logic [7:0]        uart_din,
    output logic              busy
);

    localparam int BIT_CYC   = CLK_FREQ / UART_BPS;
    localparam int FRAME_CYC = FRAME_BITS * BIT_CYC;
    localparam int CNT_W     = $clog2(FRAME_CYC + 1);
    localparam int IDX_W     = idx_width(NREQ);

    // GAP_CYC is assumed not to exceed FRAME_CYC so it fits the shared counter.
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(NREQ - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [7:0]       r_uart_din;

    logic [IDX_W-1:0] w_last;
    logic [NREQ-1:0]  w_onehot;
    logic [IDX_W-1:0] w_idx;
    logic             w_valid;
    logic             w_grant;
    logic [7:0]       w_bytes [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
        assign w_bytes[gi] = din[8*gi +: 8];
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (req),
        .i_last  (w_last),
        .o_gnt   (w_onehot),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // A grant is only ever issued from IDLE, and never while reset is held.
    assign w_grant = (r_state == IDLE) && w_valid && !sys_rst;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Pinning the pointer to NREQ-1 makes the search always start at index 0.
    assign w_last = LAST_INIT;
`else
    logic [IDX_W-1:0] r_last;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_last <= LAST_INIT;
        end else if (w_grant) begin
            r_last <= w_idx;
        end
    end

    assign w_last = r_last;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_state_next = SEND;
                w_cnt_next   = '0;
            end
            SEND: begin
                if (r_cnt == FRAME_LAST) begin
                    w_state_next = (GAP_CYC == 0) ? IDLE : GAP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_uart_din <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_grant) begin
                r_uart_din <= w_bytes[w_idx];
            end
        end
    end

    assign gnt      = w_grant ? w_onehot : '0;
    assign uart_en  = (r_state == LOAD);
    assign uart_din = r_uart_din;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLK_FREQ=1000, UART_BPS=100, NREQ=4, GAP_CYC=2.
// Define UART_ARB_FIXED_PRIO_EN here as well when building the fixed-priority variant.
module tb_uart_tx_arbiter;

    localparam int PERIOD = 104;
    localparam int BUSY_CYC = 103;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  req = 4'h0;
    logic [31:0] din = 32'h0;
    logic [3:0]  gnt;
    logic        uart_en;
    logic [7:0]  uart_din;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_arbiter #(
        .CLK_FREQ (1000),
        .UART_BPS (100),
        .NREQ     (4),
        .GAP_CYC  (2)
    ) dut (
        .sys_clk  (clk),
        .sys_rst  (sys_rst),
        .req      (req),
        .din      (din),
        .gnt      (gnt),
        .uart_en  (uart_en),
        .uart_din (uart_din),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drains any frame in flight; reports whether IDLE was reached in time.
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        int bad_cyc = 0;
        req = 4'hF;
        sys_rst = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (gnt !== 4'h0) begin n_bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (uart_en !== 1'b0) begin n_bad++; $display("FAIL rst_uart_en: got %b want 0", uart_en); end
        n_cmp++; if (uart_din !== 8'h00) begin n_bad++; $display("FAIL rst_uart_din: got %h want 00", uart_din); end
        req = 4'h0;
        step();
        sys_rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (gnt !== 4'h0 || busy !== 1'b0 || uart_en !== 1'b0 || uart_din !== 8'h00) bad_cyc++;
            step();
        end
        n_cmp++; if (bad_cyc !== 0) begin n_bad++; $display("FAIL idle_200: %0d non-zero cycles, want 0", bad_cyc); end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        int  nbusy = 1;
        int  bad_cyc = 0;
        bit  ok;
        din = 32'h00A5_0000;
        req = 4'b0100;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt: got %b want 0100", gnt); end
        n_cmp++; if (uart_en !== 1'b0) begin n_bad++; $display("FAIL single_en_early: got %b want 0", uart_en); end
        step();
        req = 4'b0000;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_gnt_once: got %b want 0000", gnt); end
        n_cmp++; if (uart_en !== 1'b1) begin n_bad++; $display("FAIL single_en: got %b want 1", uart_en); end
        n_cmp++; if (uart_din !== 8'hA5) begin n_bad++; $display("FAIL single_din: got %h want a5", uart_din); end
        for (int c = 0; c < 300; c++) begin
            step();
            @(negedge clk);
            if (!busy) break;
            nbusy++;
            if (uart_en !== 1'b0 || gnt !== 4'h0 || uart_din !== 8'hA5) bad_cyc++;
        end
        n_cmp++; if (nbusy !== BUSY_CYC) begin n_bad++; $display("FAIL single_busy_len: got %0d want %0d", nbusy, BUSY_CYC); end
        n_cmp++; if (bad_cyc !== 0) begin n_bad++; $display("FAIL single_send_hold: %0d bad cycles, want 0", bad_cyc); end
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_idle: timeout, busy still %b", busy); end
        $display("test_single: grant at 0100, busy %0d cycles", nbusy);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        logic [7:0] exp_b [5];
        logic [3:0] got_g [5];
        int         t_g [5];
        int         ng = 0;
        bit         pend = 1'b0;
        logic [7:0] pend_b = 8'h00;
        bit         ok;
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp_b = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`else
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`endif
        din = 32'h4433_2211;
        req = 4'hF;
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
        for (int c = 0; c < 700 && (ng < 5 || pend); c++) begin
            @(negedge clk);
            if (pend) begin
                n_cmp++; if (uart_en !== 1'b1) begin n_bad++; $display("FAIL rr_en: got %b want 1", uart_en); end
                n_cmp++; if (uart_din !== pend_b) begin n_bad++; $display("FAIL rr_din: got %h want %h", uart_din, pend_b); end
                pend = 1'b0;
            end
            if (gnt !== 4'h0 && ng < 5) begin
                t_g[ng]   = c;
                got_g[ng] = gnt;
                pend_b    = exp_b[ng];
                pend      = 1'b1;
                ng++;
            end
            step();
        end
        req = 4'h0;
        n_cmp++; if (ng !== 5) begin n_bad++; $display("FAIL rr_count: got %0d grants want 5", ng); end
        for (int i = 0; i < ng; i++) begin
            $display("test_round_robin: grant %0d = %b at cycle %0d", i, got_g[i], t_g[i]);
            n_cmp++; if (got_g[i] !== exp_g[i]) begin n_bad++; $display("FAIL rr_gnt%0d: got %b want %b", i, got_g[i], exp_g[i]); end
            if (i > 0) begin
                n_cmp++;
                if (t_g[i] - t_g[i-1] !== PERIOD) begin
                    n_bad++; $display("FAIL rr_period%0d: got %0d want %0d", i, t_g[i] - t_g[i-1], PERIOD);
                end
            end
        end
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rr_idle: timeout, busy still %b", busy); end
    endtask

    task automatic test_reset_in_send();
        bit ok;
        sys_rst = 1'b1;
        req = 4'h0;
        step();
        sys_rst = 1'b0;
        din = 32'h0000_C35A;
        req = 4'b0001;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rs_first_gnt: got %b want 0001", gnt); end
        step();
        req = 4'b0000;
        repeat (51) step();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rs_in_send: busy %b want 1", busy); end
        step();
        sys_rst = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rs_busy: got %b want 0", busy); end
        n_cmp++; if (uart_din !== 8'h00) begin n_bad++; $display("FAIL rs_din: got %h want 00", uart_din); end
        n_cmp++; if (gnt !== 4'h0) begin n_bad++; $display("FAIL rs_gnt_in_rst: got %b want 0000", gnt); end
        step();
        sys_rst = 1'b0;
        req = 4'b0010;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL rs_gnt_after: got %b want 0010", gnt); end
        step();
        req = 4'b0000;
        @(negedge clk);
        n_cmp++; if (uart_din !== 8'hC3) begin n_bad++; $display("FAIL rs_din_after: got %h want c3", uart_din); end
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rs_idle: timeout, busy still %b", busy); end
        $display("test_reset_in_send: done");
    endtask

    task automatic test_late_request();
        int         t_next = -1;
        logic [3:0] g_next = 4'h0;
        bit         ok;
        sys_rst = 1'b1;
        req = 4'h0;
        step();
        sys_rst = 1'b0;
        din = 32'h9600_0077;
        req = 4'b1000;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL late_gnt3: got %b want 1000", gnt); end
        for (int c = 1; c < 250; c++) begin
            step();
            if (c == 1) req = 4'b0000;
            if (c == 50) req = 4'b0001;
            @(negedge clk);
            if (gnt !== 4'h0) begin
                t_next = c;
                g_next = gnt;
                break;
            end
        end
        n_cmp++; if (g_next !== 4'b0001) begin n_bad++; $display("FAIL late_gnt0: got %b want 0001", g_next); end
        n_cmp++; if (t_next !== PERIOD) begin n_bad++; $display("FAIL late_spacing: got %0d want %0d", t_next, PERIOD); end
        step();
        req = 4'h0;
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL late_idle: timeout, busy still %b", busy); end
        $display("test_late_request: gnt %b after %0d cycles", g_next, t_next);
    endtask

    task automatic test_hold_single();
        int  t_g [3];
        int  ng = 0;
        bit  ok;
        din = 32'h0042_0000;
        req = 4'b0100;
        for (int c = 0; c < 400 && ng < 3; c++) begin
            @(negedge clk);
            if (gnt !== 4'h0) begin
                n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL hold_gnt: got %b want 0100", gnt); end
                t_g[ng] = c;
                ng++;
            end
            step();
        end
        req = 4'h0;
        n_cmp++; if (ng !== 3) begin n_bad++; $display("FAIL hold_count: got %0d want 3", ng); end
        if (ng == 3) begin
            n_cmp++; if (t_g[2] - t_g[0] !== 2 * PERIOD) begin n_bad++; $display("FAIL hold_period: got %0d want %0d", t_g[2] - t_g[0], 2 * PERIOD); end
        end
        wait_idle(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL hold_idle: timeout, busy still %b", busy); end
        $display("test_hold_single: %0d grants", ng);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_reset_in_send();
        test_late_request();
        test_hold_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
